// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
//
// Purpose:
//   Shared definitions for the registered bitwise logic unit. These cover the
//   opcode encoding, the opcode width, and a helper that classifies the
//   opcodes that touch the accumulator.
//
// Contents:
//   OP_W              opcode width (fixed at 3)
//   OP_AND..OP_ACC_LOAD  opcode values
//   is_acc_op()       1 for opcodes that write the accumulator
// ---------------------------------------------------------------------------
package logic_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND      = 3'd0;
  localparam logic [OP_W-1:0] OP_OR       = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR      = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND     = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR      = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR     = 3'd5;
  localparam logic [OP_W-1:0] OP_ACC_OR   = 3'd6;
  localparam logic [OP_W-1:0] OP_ACC_LOAD = 3'd7;

  // Only the two accumulator opcodes may update acc_q. Every other opcode
  // leaves the accumulator untouched.
  function automatic logic is_acc_op(input logic [OP_W-1:0] op);
    return (op == OP_ACC_OR) || (op == OP_ACC_LOAD);
  endfunction

endpackage : logic_unit_pkg

// File: rtl/logic_unit_core.sv
// ---------------------------------------------------------------------------
// logic_unit_core
//
// Purpose:
//   Purely combinational datapath of the logic unit. It computes the result
//   for one opcode, along with the accumulator's next value and its write
//   enable. It contains no state. The enclosing pipe decides whether the
//   result is actually captured.
//
// Parameters:
//   WIDTH     operand/result width (>=1)
//
// Ports:
//   op        in   OP_W   opcode
//   a, b      in   WIDTH  operands
//   acc       in   WIDTH  current accumulator value
//   y         out  WIDTH  result for this opcode
//   acc_next  out  WIDTH  accumulator value to store when acc_we=1
//   acc_we    out  1      opcode writes the accumulator
// ---------------------------------------------------------------------------
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc_next,
  output logic             acc_we
);

  // All operations are bitwise at WIDTH. The inverting ops flip every bit,
  // so no carries or partial widths are involved.
  always_comb begin
    y        = '0;
    acc_next = acc;
    acc_we   = is_acc_op(op);
    case (op)
      OP_AND:      y = a & b;
      OP_OR:       y = a | b;
      OP_XOR:      y = a ^ b;
      OP_NAND:     y = ~(a & b);
      OP_NOR:      y = ~(a | b);
      OP_XNOR:     y = ~(a ^ b);
      OP_ACC_OR: begin
        y        = acc | a | b;
        acc_next = acc | a | b;
      end
      OP_ACC_LOAD: begin
        // Operand b is deliberately ignored when loading the accumulator.
        y        = a;
        acc_next = a;
      end
      default: begin
        y        = '0;
        acc_next = acc;
      end
    endcase
  end

endmodule : logic_unit_core

// File: rtl/logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// logic_unit_pipe
//
// Purpose:
//   Registered N-bit bitwise logic unit with a valid/ready handshake and a
//   single output register stage. It sustains one beat per cycle while
//   out_ready is high. It selects one of six bitwise ops, or an OR-accumulate
//   or accumulator-load operation, for each transaction.
//
// Optional feature (macro LOGIC_UNIT_FLAGS_EN):
//   When this macro is defined, registered status outputs out_zero
//   (out_y == 0) and out_parity (XOR-reduce of out_y) are added.
//
// Parameters:
//   WIDTH      operand/result width (>=1)
//   OP_W       opcode width (fixed at 3)
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      unit can accept a beat this cycle
//   in_op      in   OP_W   opcode, sampled with operands
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   out_valid  out  1      result register holds a valid beat
//   out_ready  in   1      downstream accepts result
//   out_y      out  WIDTH  registered result
//   acc_q      out  WIDTH  current accumulator value
//   out_zero   out  1      (LOGIC_UNIT_FLAGS_EN) out_y == 0
//   out_parity out  1      (LOGIC_UNIT_FLAGS_EN) ^out_y
// ---------------------------------------------------------------------------
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] acc_q
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic             fire;
  logic             retire;

  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_y_q;
  logic [WIDTH-1:0] out_y_d;
  logic [WIDTH-1:0] acc_d;

  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_acc_next;
  logic             core_acc_we;

  // The unit can accept a beat whenever the slot is empty or is being drained
  // this cycle. This gives full throughput under continuous out_ready.
  assign in_ready = !out_valid_q || out_ready;
  assign fire     = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op       (in_op),
    .a        (in_a),
    .b        (in_b),
    .acc      (acc_q),
    .y        (core_y),
    .acc_next (core_acc_next),
    .acc_we   (core_acc_we)
  );

  // Next-state selection. The core's outputs are only used under fire. This
  // keeps X or garbage on idle operand inputs out of the registers.
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    acc_d       = acc_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_y_d     = core_y;
      if (core_acc_we) begin
        acc_d = core_acc_next;
      end
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic out_zero_q;
  logic out_zero_d;
  logic out_parity_q;
  logic out_parity_d;

  // The flags are computed from the incoming result rather than from out_y_q.
  // This makes them change on the same edge as out_y and hold with it.
  always_comb begin
    out_zero_d   = out_zero_q;
    out_parity_d = out_parity_q;
    if (fire) begin
      out_zero_d   = (core_y == '0);
      out_parity_d = ^core_y;
    end
  end

  // The reset values describe the cleared result (all zeros): zero=1, parity=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_zero_q   <= 1'b1;
      out_parity_q <= 1'b0;
    end else begin
      out_zero_q   <= out_zero_d;
      out_parity_q <= out_parity_d;
    end
  end

  assign out_zero   = out_zero_q;
  assign out_parity = out_parity_q;
`else
  // The status flags are not built in this configuration.
`endif

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Self-checking bench for logic_unit_pipe (WIDTH=8). A behavioural model
// tracks the output slot and the accumulator using per-bit truth tables.
// Each scenario task drives stimulus and compares the DUT against constants
// and the model. Flag checks are compiled in when LOGIC_UNIT_FLAGS_EN is
// defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_unit_pipe;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_y;
  logic [W-1:0] acc_q;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic         out_zero;
  logic         out_parity;
`endif

  int vectors;
  int miscompares;

  // Behavioural model state
  logic         m_valid;
  logic [W-1:0] m_y;
  logic [W-1:0] m_acc;

  logic_unit_pipe #(
    .WIDTH (W),
    .OP_W  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .acc_q     (acc_q)
`ifdef LOGIC_UNIT_FLAGS_EN
    ,
    .out_zero   (out_zero),
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result computed bit by bit from a 2-input truth table. The
  // table is indexed by {a_i, b_i}. The accumulator ops are spelled out
  // directly from their definitions.
  function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic [W-1:0] acc);
    logic [3:0]   tt;
    logic [W-1:0] r;
    r = '0;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0110;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < W; i++) begin
      if (op == 3'd6)      r[i] = acc[i] | a[i] | b[i];
      else if (op == 3'd7) r[i] = a[i];
      else                 r[i] = tt[{a[i], b[i]}];
    end
    return r;
  endfunction

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic step();
    logic         fire;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ordy;
    fire = in_valid && (!m_valid || out_ready);
    op   = in_op;
    a    = in_a;
    b    = in_b;
    ordy = out_ready;
    @(posedge clk);
    if (fire) begin
      m_y     = ref_result(op, a, b, m_acc);
      if (op == 3'd6 || op == 3'd7) m_acc = m_y;
      m_valid = 1'b1;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, '0, '0);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    #12;
    rst_n = 1'b1;
    m_valid = 1'b0;
    m_y     = '0;
    m_acc   = '0;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid);
    end
    vectors++;
    if (out_y !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_out_y got=%02h exp=00", out_y);
    end
    vectors++;
    if (acc_q !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_acc_q got=%02h exp=00", acc_q);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready);
    end
`ifdef LOGIC_UNIT_FLAGS_EN
    vectors++;
    if (out_zero !== 1'b1 || out_parity !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got=%0b%0b exp=10", out_zero, out_parity);
    end
`endif
  endtask

  task automatic test_logic_ops();
    logic [W-1:0] exp_tab [6];
    exp_tab = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'(i), 8'hC3, 8'h5A);
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_y !== exp_tab[i] || out_y !== m_y) begin
        miscompares++;
        $display("[TB] FAIL logic_op%0d got=%0b/%02h exp=1/%02h", i, out_valid, out_y, exp_tab[i]);
      end
      vectors++;
      if (acc_q !== 8'h00) begin
        miscompares++;
        $display("[TB] FAIL logic_op%0d_acc got=%02h exp=00", i, acc_q);
      end
    end
`ifdef LOGIC_UNIT_FLAGS_EN
    drive(1'b1, 3'd2, 8'hC3, 8'hC3);
    step();
    vectors++;
    if (out_y !== 8'h00 || out_zero !== 1'b1 || out_parity !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL xor_flags got=%02h/%0b%0b exp=00/10", out_y, out_zero, out_parity);
    end
    drive(1'b1, 3'd0, 8'h07, 8'h03);
    step();
    vectors++;
    if (out_zero !== 1'b0 || out_parity !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL and_flags got=%0b%0b exp=00", out_zero, out_parity);
    end
`endif
    drive(1'b0, 3'd0, '0, '0);
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ops_drain got=%0b exp=0", out_valid);
    end
  endtask

  task automatic test_accumulate();
    logic [2:0]   ops  [3];
    logic [W-1:0] as   [3];
    logic [W-1:0] bs   [3];
    logic [W-1:0] exps [3];
    ops  = '{3'd7, 3'd6, 3'd6};
    as   = '{8'h01, 8'h10, 8'h00};
    bs   = '{8'hEE, 8'h00, 8'h80};
    exps = '{8'h01, 8'h11, 8'h91};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], as[i], bs[i]);
      step();
      vectors++;
      if (out_y !== exps[i] || acc_q !== exps[i] || out_y !== m_y) begin
        miscompares++;
        $display("[TB] FAIL acc_step%0d got=%02h acc=%02h exp=%02h", i, out_y, acc_q, exps[i]);
      end
    end
    drive(1'b0, 3'd0, '0, '0);
    step();
    vectors++;
    if (acc_q !== 8'h91) begin
      miscompares++;
      $display("[TB] FAIL acc_final got=%02h exp=91", acc_q);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    drive(1'b1, 3'd0, 8'hFF, 8'h0F);
    step();
    out_ready = 1'b0;
    drive(1'b1, 3'd1, 8'hF0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall%0d_in_ready got=%0b exp=0", i, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_y !== 8'h0F || acc_q !== m_acc) begin
        miscompares++;
        $display("[TB] FAIL stall%0d_hold got=%0b/%02h exp=1/0f", i, out_valid, out_y);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release_in_ready got=%0b exp=1", in_ready);
    end
    step();
    vectors++;
    if (out_valid !== 1'b1 || out_y !== 8'hF1) begin
      miscompares++;
      $display("[TB] FAIL release_beat got=%0b/%02h exp=1/f1", out_valid, out_y);
    end
    drive(1'b0, 3'd0, '0, '0);
    step();
    vectors++;
    if (out_valid !== 1'b0 || out_y !== 8'hF1) begin
      miscompares++;
      $display("[TB] FAIL retire_hold got=%0b/%02h exp=0/f1", out_valid, out_y);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d_bubble in_ready=%0b exp=1", i, in_ready);
      end
      step();
      vectors++;
      if (out_valid !== 1'b1 || out_y !== m_y || acc_q !== m_acc) begin
        miscompares++;
        $display("[TB] FAIL b2b%0d got=%0b/%02h/%02h exp=1/%02h/%02h", i, out_valid, out_y, acc_q, m_y, m_acc);
      end
    end
    drive(1'b0, 3'd0, '0, '0);
    step();
  endtask

  task automatic test_random_flow();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_in_ready got=%0b exp=%0b", i, in_ready, (!m_valid || out_ready));
      end
      step();
      vectors++;
      if (out_valid !== m_valid || out_y !== m_y || acc_q !== m_acc) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d got=%0b/%02h/%02h exp=%0b/%02h/%02h", i, out_valid, out_y, acc_q, m_valid, m_y, m_acc);
      end
`ifdef LOGIC_UNIT_FLAGS_EN
      vectors++;
      if (out_zero !== (m_y == '0) || out_parity !== (^m_y)) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_flags got=%0b%0b", i, out_zero, out_parity);
      end
`endif
    end
    drive(1'b0, 3'd0, '0, '0);
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 8'h91, 8'h00);
    step();
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 8'hAA, 8'hFF);
    step();
    step();
    vectors++;
    if (out_valid !== 1'b1 || acc_q !== 8'h91) begin
      miscompares++;
      $display("[TB] FAIL pre_reset got=%0b/%02h exp=1/91", out_valid, acc_q);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || acc_q !== 8'h00 || out_y !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL async_reset got=%0b/%02h/%02h exp=0/00/00", out_valid, acc_q, out_y);
    end
`ifdef LOGIC_UNIT_FLAGS_EN
    vectors++;
    if (out_zero !== 1'b1 || out_parity !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_reset_flags got=%0b%0b exp=10", out_zero, out_parity);
    end
`endif
    drive(1'b0, 3'd0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    m_valid = 1'b0;
    m_y     = '0;
    m_acc   = '0;
    step();
    vectors++;
    if (out_valid !== 1'b0 || acc_q !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL post_reset got=%0b/%02h exp=0/00", out_valid, acc_q);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    in_valid    = 1'b0;
    in_op       = '0;
    in_a        = '0;
    in_b        = '0;
    m_valid     = 1'b0;
    m_y         = '0;
    m_acc       = '0;
    test_reset();
    test_logic_ops();
    test_accumulate();
    test_backpressure();
    test_back_to_back();
    test_random_flow();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_logic_unit_pipe
